// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point normalization path.
package fp_pkg;

    localparam int MANT_BITS_DEF = 23;
    localparam int EXP_BITS_DEF  = 8;

    localparam logic [EXP_BITS_DEF-1:0] EXP_MAX      = '1;
    localparam logic [EXP_BITS_DEF-1:0] EXP_MIN_NORM = EXP_BITS_DEF'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } fp_norm_state_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter: number of zeros above the most significant set bit.
// An all-zero input reports 0; callers screen that case out beforehand.
module fp_lzc #(
    parameter int W  = 24,
    parameter int CW = $clog2(W)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_norm_ctrl.sv
// Normalization sequencer between the significand adder and the pack stage.
// Define FP_NORM_LZC_EN for single-cycle normalization via a leading-zero counter.
module fp_norm_ctrl
    import fp_pkg::*;
#(
    parameter int MANT_BITS = MANT_BITS_DEF,
    parameter int EXP_BITS  = EXP_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MANT_BITS+1:0] in_mant,
    input  logic [EXP_BITS-1:0]  in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MANT_BITS-1:0] out_frac,
    output logic [EXP_BITS-1:0]  out_exp,
    output logic                 out_zero,
    output logic                 out_underflow,
    output logic                 out_overflow
);

    localparam logic [EXP_BITS-1:0] EXP_ONES = '1;
    localparam logic [EXP_BITS-1:0] EXP_MIN  = EXP_BITS'(EXP_MIN_NORM);

    fp_norm_state_t       state_reg, state_next;
    logic [MANT_BITS+1:0] mant_reg, mant_next;
    logic [EXP_BITS-1:0]  exp_reg, exp_next;
    logic                 zero_reg, zero_next;
    logic                 unf_reg, unf_next;
    logic                 ovf_reg, ovf_next;
    logic [EXP_BITS-1:0]  exp_inc;

    assign exp_inc = exp_reg + 1'b1;

`ifdef FP_NORM_LZC_EN
    localparam int LZ_W = $clog2(MANT_BITS + 1);
    logic [LZ_W-1:0]     lz_cnt;
    logic [EXP_BITS-1:0] lz_ext, exp_dec, shift_amt;

    fp_lzc #(.W(MANT_BITS + 1), .CW(LZ_W)) u_lzc (
        .value (mant_reg[MANT_BITS:0]),
        .count (lz_cnt)
    );

    // Shift is clamped so the exponent bottoms out at 1; a shortfall means denormal.
    assign lz_ext    = EXP_BITS'(lz_cnt);
    assign exp_dec   = exp_reg - 1'b1;
    assign shift_amt = (lz_ext < exp_dec) ? lz_ext : exp_dec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mant_reg  <= '0;
            exp_reg   <= '0;
            zero_reg  <= 1'b0;
            unf_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mant_reg  <= mant_next;
            exp_reg   <= exp_next;
            zero_reg  <= zero_next;
            unf_reg   <= unf_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mant_next  = mant_reg;
        exp_next   = exp_reg;
        zero_next  = zero_reg;
        unf_next   = unf_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = NORM;
                    mant_next  = in_mant;
                    exp_next   = in_exp;
                    zero_next  = 1'b0;
                    unf_next   = 1'b0;
                    ovf_next   = 1'b0;
                end
            end
            NORM: begin
                state_next = DONE;
                if (exp_reg == EXP_ONES) begin
                    state_next = DONE;
                end else if (mant_reg == '0) begin
                    zero_next = 1'b1;
                    exp_next  = '0;
                end else if (mant_reg[MANT_BITS+1]) begin
                    mant_next = mant_reg >> 1;
                    exp_next  = exp_inc;
                    if (exp_inc == EXP_ONES) begin
                        ovf_next                 = 1'b1;
                        mant_next[MANT_BITS-1:0] = '0;
                    end
                end else if (mant_reg[MANT_BITS]) begin
                    state_next = DONE;
                end else if (exp_reg <= EXP_MIN) begin
                    exp_next = '0;
                    unf_next = 1'b1;
                end else begin
`ifdef FP_NORM_LZC_EN
                    mant_next = mant_reg << shift_amt;
                    exp_next  = exp_reg - shift_amt;
                    if (shift_amt < lz_ext) begin
                        exp_next = '0;
                        unf_next = 1'b1;
                    end
`else
                    mant_next  = mant_reg << 1;
                    exp_next   = exp_reg - 1'b1;
                    state_next = NORM;
`endif
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (state_reg == IDLE);
        out_valid     = (state_reg == DONE);
        out_frac      = mant_reg[MANT_BITS-1:0];
        out_exp       = exp_reg;
        out_zero      = zero_reg;
        out_underflow = unf_reg;
        out_overflow  = ovf_reg;
    end

endmodule

// File: tb/tb_fp_norm_ctrl.sv
// Randomized self-checking bench for fp_norm_ctrl against an arithmetic reference.
// Build with FP_NORM_LZC_EN defined to check the single-cycle variant.
module tb_fp_norm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [22:0] out_frac;
    logic [7:0]  out_exp;
    logic        out_zero, out_underflow, out_overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_norm_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mant       (in_mant),
        .in_exp        (in_exp),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_frac      (out_frac),
        .out_exp       (out_exp),
        .out_zero      (out_zero),
        .out_underflow (out_underflow),
        .out_overflow  (out_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Value-level reference: locate the leading one, shift as far as the exponent allows.
    function automatic void ref_model(input logic [24:0] m, input logic [7:0] e,
                                      output logic [22:0] f, output logic [7:0] eo,
                                      output logic z, output logic u, output logic o,
                                      output int lat);
        int ex, p, need, sh;
        longint mm;
        ex = int'(e); z = 0; u = 0; o = 0; sh = 0; f = m[22:0];
        if (e == 8'hFF) begin
            ex = 255;
        end else if (m == 0) begin
            z = 1; ex = 0;
        end else if (m[24]) begin
            ex = ex + 1;
            f  = m[23:1];
            if (ex == 255) begin o = 1; f = '0; end
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (m[i]) p = i;
            need = 23 - p;
            if (need == 0) begin
                sh = 0;
            end else if (ex - 1 >= need) begin
                sh = need; ex = ex - need;
            end else begin
                sh = (ex > 1) ? ex - 1 : 0;
                ex = 0; u = 1;
            end
            mm = longint'(m) << sh;
            f  = mm[22:0];
        end
        eo = ex[7:0];
`ifdef FP_NORM_LZC_EN
        lat = 1;
`else
        lat = 1 + sh;
`endif
    endfunction

    task automatic check_outputs(input string tag, input logic [22:0] f, input logic [7:0] e,
                                 input logic z, input logic u, input logic o);
        chk({tag, "_frac"}, 32'(out_frac), 32'(f));
        chk({tag, "_exp"},  32'(out_exp), 32'(e));
        chk({tag, "_flags"}, {29'd0, out_zero, out_underflow, out_overflow}, {29'd0, z, u, o});
    endtask

    task automatic run_op(input logic [24:0] m, input logic [7:0] e, input int hold);
        logic [22:0] ef; logic [7:0] ee; logic ez, eu, eo; int elat, lat;
        ref_model(m, e, ef, ee, ez, eu, eo, elat);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_mant = m; in_exp = e; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(elat));
        check_outputs("result", ef, ee, ez, eu, eo);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            check_outputs("hold", ef, ee, ez, eu, eo);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handoff_valid", 32'(out_valid), 32'd0);
        $display("op mant=%07h exp=%0d -> frac=%06h exp=%0d z=%0b u=%0b o=%0b lat=%0d",
                 m, e, out_frac, out_exp, out_zero, out_underflow, out_overflow, lat);
    endtask

    initial begin
        logic [24:0] m;
        logic [7:0]  e;
        int          r;

        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        check_outputs("rst", '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(25'h0800000, 8'd127, 0);
        run_op(25'h1000001, 8'd127, 0);
        run_op(25'h1800000, 8'd254, 0);
        run_op(25'h0000001, 8'd127, 0);
        run_op(25'h0000010, 8'd3, 0);
        run_op(25'h0000000, 8'd90, 0);
        run_op(25'h0000300, 8'd255, 0);
        run_op(25'h0400000, 8'd1, 0);
        run_op(25'h0123456, 8'd100, 5);
        run_op(25'h0000040, 8'd17, 0);

        // Abort a long normalization with reset; nothing may be emitted.
        in_mant = 25'h0000001; in_exp = 8'd127; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        check_outputs("abort", '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle_valid", 32'(out_valid), 32'd0);
        run_op(25'h0000001, 8'd127, 0);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 5);
            case (r)
                0:       m = '0;
                1:       m = {1'b1, 24'($urandom)};
                2:       m = {2'b01, 23'($urandom)};
                default: m = 25'($urandom) >> $urandom_range(1, 24);
            endcase
            r = $urandom_range(0, 7);
            if (r == 0)      e = 8'($urandom_range(0, 5));
            else if (r == 1) e = 8'($urandom_range(254, 255));
            else             e = 8'($urandom_range(0, 255));
            run_op(m, e, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_norm_ctrl.md
# fp_norm_ctrl

Multi-cycle normalization sequencer for the floating-point datapath. Takes a raw post-add/sub significand with carry and hidden-bit positions, plus a biased exponent, and steers the 23-bit fraction and exponent registers through right/left shifts until the result is normalized. Flags zero, underflow (denormal) and overflow (infinity). Sits between the significand adder and the result pack stage, with valid/ready handshakes on both sides.

## Interface
- `MANT_BITS`, 23, stored fraction width.
- `EXP_BITS`, 8, biased exponent width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input operand valid.
- `in_ready`  out  1  block can accept; equals `state==IDLE`.
- `in_mant`  in  MANT_BITS+2  raw significand: bit MANT_BITS+1 = carry, bit MANT_BITS = hidden, lower bits = fraction.
- `in_exp`  in  EXP_BITS  biased exponent.
- `out_valid`  out  1  result valid; high only in `DONE`.
- `out_ready`  in  1  downstream accepts the result.
- `out_frac`  out  MANT_BITS  normalized fraction, hidden bit stripped.
- `out_exp`  out  EXP_BITS  result biased exponent.
- `out_zero`, `out_underflow`, `out_overflow`  out  1 each  result flags.

## Operation
- States: `IDLE`, `NORM`, `DONE`.
- **`IDLE`:** on `in_valid && in_ready`, capture `in_mant` into the internal mantissa register and `in_exp` into the exponent register, clear flags, go to `NORM`.
- **`NORM`:** evaluates once per cycle. The first matching rule applies:
  1. Exponent equals all-ones: pass through unchanged (inf/NaN), then `DONE`.
  2. Mantissa equals 0: set `out_zero`, set exponent to 0, then `DONE`.
  3. Carry bit is 1: shift right by 1 (LSB truncated) and increment the exponent. If the new exponent is all-ones, set `out_overflow` and force the fraction to 0. Then `DONE`.
  4. Hidden bit is 1: go to `DONE` with no change.
  5. Exponent is 1 or less: the result is denormal. Set exponent to 0, set `out_underflow`, leave the fraction unshifted, then `DONE`.
  6. Otherwise: shift left by 1 and decrement the exponent. Stay in `NORM`.
- **`DONE`:** `out_*` are driven from the registers and held stable while `out_ready=0`. On `out_ready=1`, go to `IDLE`.
- Exponent arithmetic is unsigned EXP_BITS wide. The rules above guarantee it never wraps.

## Timing
- Reset (`rst_n=0`, any state, asynchronous):
  - state is `IDLE`;
  - all data and flag registers are 0;
  - `out_valid=0`;
  - `in_ready=1`, but transfers are ignored while `rst_n` is low.
- Reset during `NORM` or `DONE` discards the operation; no result is emitted.
- Latency is measured from the accept edge to the first `out_valid` cycle: 1 + k cycles, where k is the number of left shifts.
  - Carry, already-normal, zero, inf/NaN: 1 cycle.
  - Worst case without LZC (`in_mant=1`, large exponent): 23 shifts, 24 cycles.
- `DONE` to `IDLE` takes one edge. The next accept is possible 1 cycle after output handoff, because `in_ready` is low in `DONE`.
- `out_*` are registered outputs with no combinational path from inputs.

## Configuration
- `FP_NORM_LZC_EN` defined:
  - `NORM` computes the leading-zero count of the hidden+fraction field.
  - It applies the full left shift, clamped to `exp-1`, in a single cycle.
  - All cases have a latency of 1 cycle.
  - Flags and results are identical to the iterative build.
- Undefined: iterative 1-bit-per-cycle shifting as described above, and no LZC logic is instantiated.

## Structure
- Shared package `fp_pkg` holds:
  - the state encoding `fp_norm_state_t`: `IDLE`, `NORM`, `DONE`;
  - `EXP_MAX` (all-ones) and `EXP_MIN_NORM` (1) constants;
  - default widths.
- Sub-module `fp_lzc` (parameterized leading-zero counter, MANT_BITS+1 in, $clog2 out) is instantiated only under `FP_NORM_LZC_EN`.

## Test plan
- `in_mant=25'h0800000`, `in_exp=127`: `out_valid` after 1 cycle, frac=0, exp=127, no flags.
- `in_mant=25'h1000001`, `exp=127`: frac=0, exp=128 after 1 cycle. Then `in_mant=25'h1800000`, `exp=254`: exp=255, frac=0, `out_overflow=1`.
- `in_mant=25'h0000001`, `exp=127`: exp=104, frac=0. Latency is 24 cycles iterative and 1 cycle with `FP_NORM_LZC_EN`.
- `in_mant=25'h0000010`, `exp=3`: exp=0, frac=`23'h000040`, `out_underflow=1`. `in_mant=0`, `exp=90`: `out_zero=1`, exp=0, latency 1.
- Hold `out_ready=0` for 5 cycles in `DONE`: outputs stable and `in_ready=0`. Then `out_ready=1`: `IDLE` next cycle and a back-to-back operand is accepted.
- Assert `rst_n=0` in the middle of a 23-shift normalization: immediately `out_valid=0`, all outputs 0. After release, `in_ready=1` and a fresh operand normalizes correctly.
